// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: the default
// operand width and the controller state encoding.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder: the single datapath cell that the serial controller
// reuses once per operand bit.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule : full_adder

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Operands are captured on an accepted start,
// then one full adder consumes one bit per clock, LSB first. The finished
// sum and carry are published together with a one-cycle done pulse and
// held until the next operation completes.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  // Counter must be able to hold WIDTH-1 and the value it increments to.
  localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q;
  logic [WIDTH-1:0] a_sh_d, b_sh_d, s_sh_d;
  logic             cy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic             sum_bit_d;
  logic             carry_d;

  // Bit-slice datapath: current LSBs of both operands plus the running carry.
  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (cy_q),
    .s_o (sum_bit_d),
    .c_o (carry_d)
  );

  // Next values of the shift registers for one ADD step; the new sum bit
  // enters at the MSB so that after WIDTH steps bit 0 holds the first result.
  always_comb begin
    // NOTE: every variable gets a default before any conditional logic so
    // no path leaves it unassigned, which would infer a latch.
    a_sh_d            = a_sh_q >> 1;
    b_sh_d            = b_sh_q >> 1;
    s_sh_d            = s_sh_q >> 1;
    s_sh_d[WIDTH-1]   = sum_bit_d;
  end

  // Controller FSM with counter, shift registers and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            a_sh_q  <= a_in;
            b_sh_q  <= b_in;
            cy_q    <= c_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ADD;
          end
        end

        ST_ADD: begin
          a_sh_q <= a_sh_d;
          b_sh_q <= b_sh_d;
          s_sh_q <= s_sh_d;
          cy_q   <= carry_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // The last bit is folded in on this same edge.
            sum_q   <= s_sh_d;
            carry_q <= carry_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        // Unreachable encoding: return to IDLE, leave outputs untouched.
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign sum_out   = sum_q;
  assign carry_out = carry_q;

endmodule : serial_adder_ctrl
